// File: rtl/rr_mux_arb.sv
// Round-robin arbiter sharing one mux2-tree datapath among N requesters.
// Issues registered one-hot grants, drives the tree select and registers the selected word.
module rr_mux_arb #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       i,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] sel,
  output logic [W-1:0]         q,
  output logic                 q_vld
);

  localparam int LW = $clog2(N);
  localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_MAX);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e          state_q, state_d, state_k;
  logic [N-1:0]    gnt_q, gnt_d, gnt_k;
  logic [LW-1:0]   sel_q, sel_d;
  logic [LW-1:0]   last_q, last_d;
  logic [HW-1:0]   hold_q, hold_d, hold_k, hold_inc;
  logic [W-1:0]    q_q, q_d;
  logic            q_vld_q, q_vld_d;
  logic [N-1:0]    cand;
  logic [LW:0]     win;
  logic            owner_req, others, take;

  // Nearest candidate after 'last' wins; 'last' itself is checked last. MSB flags a hit.
  function automatic logic [LW:0] find_winner(input logic [N-1:0] c, input logic [LW-1:0] last);
    logic [LW:0]   res;
    logic [LW-1:0] idx;
    res = '0;
    for (int k = N; k >= 1; k--) begin
      idx = last + LW'(k);
      if (c[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next-state, grant selection, hold counting and datapath capture.
  always_comb begin
    state_k   = state_q;
    gnt_k     = gnt_q;
    take      = 1'b0;
    owner_req = |(req & gnt_q);
    others    = |(req & ~gnt_q);
    // Owner excluded: it only matters for forced rotation, where others exist anyway.
    cand      = req & ~gnt_q;
    win       = find_winner(cand, last_q);
    hold_inc  = (hold_q < HMAX) ? hold_q + 1'b1 : hold_q;
    hold_k    = hold_q;
    case (state_q)
      IDLE: begin
        take = |req;
      end
      BUSY: begin
        if (!owner_req) begin
          if (others) begin
            take = 1'b1;
          end else begin
            state_k = IDLE;
            gnt_k   = '0;
          end
        end else if (others && (HOLD_MAX != 0) && (hold_q == HMAX)) begin
          take = 1'b1;
        end else begin
          hold_k = hold_inc;
        end
      end
      default: begin
        state_k = IDLE;
        gnt_k   = '0;
      end
    endcase
    state_d = take ? BUSY : state_k;
    gnt_d   = take ? ({{(N-1){1'b0}}, 1'b1} << win[LW-1:0]) : gnt_k;
    sel_d   = take ? win[LW-1:0] : sel_q;
    last_d  = take ? win[LW-1:0] : last_q;
    hold_d  = take ? HW'(1) : hold_k;
    q_vld_d = |gnt_q;
    q_d     = (|gnt_q) ? i[sel_q*W +: W] : q_q;
  end

  // State registers with synchronous reset; pointer resets so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= LW'(N - 1);
      hold_q  <= '0;
      q_q     <= '0;
      q_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      q_q     <= q_d;
      q_vld_q <= q_vld_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign q     = q_q;
  assign q_vld = q_vld_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Self-checking bench for rr_mux_arb: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_rr_mux_arb;
  localparam int N = 4;
  localparam int W = 8;
  localparam int HOLD_MAX = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] i_bus = '0;
  logic [N-1:0]   gnt;
  logic [1:0]     sel;
  logic [W-1:0]   q;
  logic           q_vld;

  int checks = 0;
  int failures = 0;

  // Model state: owner index (-1 when idle), last grant, hold count, sel, q, q_vld
  int         m_owner, m_last, m_hold, m_sel;
  logic [W-1:0] m_q;
  logic       m_vld;
  logic [N-1:0] eg;
  logic [1:0]   es;

  rr_mux_arb #(.N(N), .W(W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .i(i_bus),
    .gnt(gnt), .sel(sel), .q(q), .q_vld(q_vld)
  );

  always #5 clk = ~clk;

  function automatic int pick(int excl);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (req[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic give(int w);
    m_owner = w; m_last = w; m_sel = w; m_hold = 1;
  endtask

  task automatic model_step();
    bit others;
    if (rst) begin
      m_owner = -1; m_last = N - 1; m_hold = 0; m_sel = 0; m_q = '0; m_vld = 1'b0;
      return;
    end
    m_vld = (m_owner >= 0);
    if (m_owner >= 0) m_q = i_bus[m_sel*W +: W];
    others = 0;
    for (int k = 0; k < N; k++) if (req[k] && k != m_owner) others = 1;
    if (m_owner < 0) begin
      if (others) give(pick(-1));
    end else if (!req[m_owner]) begin
      if (others) give(pick(-1));
      else m_owner = -1;
    end else if (others && HOLD_MAX != 0 && m_hold == HOLD_MAX) begin
      give(pick(m_owner));
    end else if (m_hold < HOLD_MAX) begin
      m_hold = m_hold + 1;
    end
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    es = m_sel[1:0];
  endtask

  task automatic tick();
    model_step();
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    es = m_sel[1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) rst = 1'b0;
      tick();
      checks++;
      if ({gnt, sel, q, q_vld} !== {N'(0), 2'd0, 8'h00, 1'b0}) begin
        failures++;
        $display("FAIL reset_idle c=%0d got gnt=%b sel=%0d q=%h vld=%b want all zero", c, gnt, sel, q, q_vld);
      end
    end
  endtask

  task automatic test_single();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0100; i_bus = 32'h11A5_2233;
    tick();
    checks++;
    if ({gnt, sel, q_vld} !== {4'b0100, 2'd2, 1'b0}) begin
      failures++;
      $display("FAIL single_grant got gnt=%b sel=%0d vld=%b want 0100/2/0", gnt, sel, q_vld);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if ({gnt, sel, q, q_vld} !== {4'b0100, 2'd2, 8'hA5, 1'b1}) begin
        failures++;
        $display("FAIL single_hold c=%0d got gnt=%b sel=%0d q=%h vld=%b want 0100/2/a5/1", c, gnt, sel, q, q_vld);
      end
    end
  endtask

  task automatic test_fairness();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    for (int t = 1; t <= 17; t++) begin
      i_bus = $urandom;
      tick();
      checks++;
      if (gnt !== N'(1 << (((t - 1) / 4) % 4))) begin
        failures++;
        $display("FAIL fair_order t=%0d got gnt=%b want %b", t, gnt, N'(1 << (((t - 1) / 4) % 4)));
      end
      checks++;
      if ({q, q_vld} !== {m_q, m_vld}) begin
        failures++;
        $display("FAIL fair_data t=%0d got q=%h vld=%b want %h/%b", t, q, q_vld, m_q, m_vld);
      end
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0010; tick();
    req = 4'b1010; tick();
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL handoff_owner got gnt=%b want 0010", gnt);
    end
    req = 4'b1000; tick();
    checks++;
    if ({gnt, sel, q_vld} !== {4'b1000, 2'd3, 1'b1}) begin
      failures++;
      $display("FAIL handoff_switch got gnt=%b sel=%0d vld=%b want 1000/3/1", gnt, sel, q_vld);
    end
    tick();
    checks++;
    if (q_vld !== 1'b1) begin
      failures++;
      $display("FAIL handoff_vld got %b want 1", q_vld);
    end
  endtask

  task automatic test_wrap_skip();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1000; tick();
    req = 4'b0101;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0001) begin
        failures++;
        $display("FAIL wrap_first c=%0d got gnt=%b want 0001", c, gnt);
      end
    end
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({gnt, sel} !== {4'b0100, 2'd2}) begin
        failures++;
        $display("FAIL wrap_skip c=%0d got gnt=%b sel=%0d want 0100/2", c, gnt, sel);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0100; i_bus = 32'h003C_0000;
    tick(); tick();
    checks++;
    if ({gnt, q} !== {4'b0100, 8'h3C}) begin
      failures++;
      $display("FAIL rstmid_pre got gnt=%b q=%h want 0100/3c", gnt, q);
    end
    rst = 1'b1; req = 4'b0110; tick();
    checks++;
    if ({gnt, sel, q, q_vld} !== {4'b0000, 2'd0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_clear got gnt=%b sel=%0d q=%h vld=%b want zeros", gnt, sel, q, q_vld);
    end
    rst = 1'b0; tick();
    checks++;
    if ({gnt, sel} !== {4'b0010, 2'd1}) begin
      failures++;
      $display("FAIL rstmid_rearb got gnt=%b sel=%0d want 0010/1", gnt, sel);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      i_bus = $urandom;
      rst = ($urandom_range(0, 59) == 0);
      tick();
      checks++;
      if ({gnt, sel, q, q_vld} !== {eg, es, m_q, m_vld}) begin
        failures++;
        $display("FAIL random c=%0d got gnt=%b sel=%0d q=%h vld=%b want %b/%0d/%h/%b",
                 c, gnt, sel, q, q_vld, eg, es, m_q, m_vld);
      end
      checks++;
      if ($countones(gnt) > 1) begin
        failures++;
        $display("FAIL onehot c=%0d got gnt=%b want at most one bit", c, gnt);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    m_owner = -1; m_last = N - 1; m_hold = 0; m_sel = 0; m_q = '0; m_vld = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_wrap_skip();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
